// File: rtl/mhp_pkg.sv
// Shared definitions for the frame-record memory path: default bus widths,
// requester indices and the arbiter state encoding.
package mhp_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum int unsigned {
        REQ_SCS  = 0,
        REQ_SET  = 1,
        REQ_SEND = 2
    } req_idx_e;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/bram_arbiter_rr_pick.sv
// Masked priority encoder: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic             vld
);

    int unsigned idx;

    always_comb begin
        gnt = '0;
        vld = 1'b0;
        idx = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!vld && req[IDX_W'(idx)]) begin
                gnt[IDX_W'(idx)] = 1'b1;
                vld              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Single-port BRAM arbiter with registered req/grant ownership and per-requester
// read-valid. Define BRAM_ARBITER_RR_EN for round-robin; default is fixed priority.
module bram_arbiter
    import mhp_pkg::*;
#(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ-1:0]          i_acc,
    input  logic [N_REQ-1:0]          i_we,
    input  logic [N_REQ*ADDR_W-1:0]   i_addr,
    input  logic [N_REQ*DATA_W-1:0]   i_wdata,
    output logic [N_REQ-1:0]          o_gnt,
    output logic [N_REQ-1:0]          o_rvalid,
    output logic [DATA_W-1:0]         o_rdata,
    output logic                      o_busy,
    output logic                      o_mem_en,
    output logic                      o_mem_we,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic [DATA_W-1:0]         o_mem_wdata,
    input  logic [DATA_W-1:0]         i_mem_rdata
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [N_REQ-1:0] gnt_d;
    logic [N_REQ-1:0] win_oh;
    logic             win_vld;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] pick_ptr;
    logic             acc_ok;
    logic             rd_pend_q;
    logic [IDX_W-1:0] rd_owner_q;

`ifdef BRAM_ARBITER_RR_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    logic [IDX_W-1:0] ptr_q, ptr_d;
    assign pick_ptr = ptr_q;
`else
    assign pick_ptr = '0;
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (i_req),
        .ptr (pick_ptr),
        .gnt (win_oh),
        .vld (win_vld)
    );

    always_comb begin
        win_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (win_oh[k]) win_idx = IDX_W'(k);
        end
    end

    // An access only counts while the owner still holds its request.
    assign acc_ok = (state_q == OWN) && i_req[owner_q] && i_acc[owner_q] && !i_rst;

    // State register and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            o_gnt      <= '0;
            o_busy     <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= '0;
`ifdef BRAM_ARBITER_RR_EN
            ptr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            o_gnt      <= gnt_d;
            o_busy     <= (state_d == OWN);
            rd_pend_q  <= acc_ok && !i_we[owner_q];
            rd_owner_q <= owner_q;
`ifdef BRAM_ARBITER_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    // Next state: arbitrate from IDLE or in the owner's release cycle
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        gnt_d   = o_gnt;
`ifdef BRAM_ARBITER_RR_EN
        ptr_d   = ptr_q;
`endif
        if (state_q == IDLE || !i_req[owner_q]) begin
            if (win_vld) begin
                state_d = OWN;
                owner_d = win_idx;
                gnt_d   = win_oh;
`ifdef BRAM_ARBITER_RR_EN
                ptr_d   = (win_idx == LAST_IDX) ? '0 : win_idx + IDX_W'(1);
`endif
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        end
    end

    // Memory port mux and read return
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_rvalid    = '0;
        o_rdata     = '0;
        if (acc_ok) begin
            o_mem_en = 1'b1;
            o_mem_we = i_we[owner_q];
            for (int unsigned k = 0; k < N_REQ; k++) begin
                if (owner_q == IDX_W'(k)) begin
                    o_mem_addr  = i_addr[k*ADDR_W +: ADDR_W];
                    o_mem_wdata = i_wdata[k*DATA_W +: DATA_W];
                end
            end
        end
        if (rd_pend_q && !i_rst) begin
            o_rvalid[rd_owner_q] = 1'b1;
            o_rdata              = i_mem_rdata;
        end
    end

    gnt_onehot_a: assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(o_gnt));

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboarded bench for bram_arbiter with a behavioural 1-cycle BRAM.
module tb_bram_arbiter;
    import mhp_pkg::*;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;

    typedef struct {
        int         k;
        logic [7:0] d;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req, acc, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata;
    logic            busy, mem_en, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;

    logic [DW-1:0]   bram [0:(1<<AW)-1];
    exp_t            sb[$];
    int              n_checks = 0;
    int              n_fail   = 0;
    bit              mon_en   = 1'b0;

    bram_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_acc       (acc),
        .i_we        (we),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_gnt       (gnt),
        .o_rvalid    (rvalid),
        .o_rdata     (rdata),
        .o_busy      (busy),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) bram[mem_addr] <= mem_wdata;
            mem_rdata <= bram[mem_addr];
        end
    end

    // Read-return monitor: every rvalid must match the oldest outstanding read
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            n_checks++;
            if (!$onehot0(gnt)) begin
                n_fail++;
                $display("FAIL gnt_onehot: got %b", gnt);
            end
            if (rvalid !== '0) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rvalid_unexpected: got rvalid=%b rdata=%h, expected none", rvalid, rdata);
                end else begin
                    e = sb.pop_front();
                    if (rvalid !== (3'b001 << e.k) || rdata !== e.d) begin
                        n_fail++;
                        $display("FAIL rvalid_data: got rvalid=%b rdata=%h, expected rvalid=%b rdata=%h",
                                 rvalid, rdata, 3'b001 << e.k, e.d);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int k, input logic a_v, input logic w_v,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        acc[k]             = a_v;
        we[k]              = w_v;
        addr[k*AW +: AW]   = a;
        wdata[k*DW +: DW]  = d;
    endtask

    // Owner k (already granted) writes d to a, reads it back, then releases.
    // Non-owners strobe i_acc throughout to show they are ignored.
    task automatic do_burst(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        for (int j = 0; j < int'(N); j++)
            if (j != k) set_slot(j, 1'b1, 1'b0, 10'h3FF, 8'hEE);
        set_slot(k, 1'b1, 1'b1, a, d);
        @(negedge clk);
        n_checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, a, d}) begin
            n_fail++;
            $display("FAIL burst%0d_write: got en=%b we=%b addr=%h wd=%h, expected 1 1 %h %h",
                     k, mem_en, mem_we, mem_addr, mem_wdata, a, d);
        end
        tick();
        set_slot(k, 1'b1, 1'b0, a, 8'h00);
        e.k = k;
        e.d = d;
        sb.push_back(e);
        @(negedge clk);
        n_checks++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, a}) begin
            n_fail++;
            $display("FAIL burst%0d_read: got en=%b we=%b addr=%h, expected 1 0 %h",
                     k, mem_en, mem_we, mem_addr, a);
        end
        tick();
        req[k] = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL burst%0d_release: got en=%b we=%b addr=%h wd=%h, expected all 0",
                     k, mem_en, mem_we, mem_addr, mem_wdata);
        end
        tick();
        acc = '0;
        we  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; acc = '0; we = '0; addr = '0; wdata = '0;
        tick();
        tick();
        n_checks++;
        if ({gnt, rvalid, rdata, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got gnt=%b rvalid=%b rdata=%h busy=%b, expected 0",
                     gnt, rvalid, rdata, busy);
        end
        n_checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_mem: got en=%b we=%b addr=%h wd=%h, expected 0",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_arbitration();
        int          second, third;
        logic [N-1:0] exp_g;
`ifdef BRAM_ARBITER_RR_EN
        second = 2; third = 0;
`else
        second = 0; third = 2;
`endif
        req = 3'b111;
        tick();
        n_checks++;
        if (gnt !== 3'b001) begin
            n_fail++;
            $display("FAIL arb_first: got gnt=%b, expected 001", gnt);
        end
        do_burst(0, 10'h010, 8'h11);
        n_checks++;
        if (gnt !== 3'b010 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL arb_second: got gnt=%b busy=%b, expected 010 1", gnt, busy);
        end
        req[0] = 1'b1;
        do_burst(1, 10'h020, 8'h22);
        exp_g = '0;
        exp_g[second] = 1'b1;
        n_checks++;
        if (gnt !== exp_g) begin
            n_fail++;
            $display("FAIL arb_third: got gnt=%b, expected %b", gnt, exp_g);
        end
        do_burst(second, 10'h030, 8'h33);
        exp_g = '0;
        exp_g[third] = 1'b1;
        n_checks++;
        if (gnt !== exp_g) begin
            n_fail++;
            $display("FAIL arb_fourth: got gnt=%b, expected %b", gnt, exp_g);
        end
        do_burst(third, 10'h040, 8'h44);
        n_checks++;
        if (gnt !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL arb_idle: got gnt=%b busy=%b, expected 000 0", gnt, busy);
        end
    endtask

    task automatic test_single();
        int   s;
        exp_t e;
        s = int'(REQ_SET);
        req[s] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (gnt !== '0) begin
            n_fail++;
            $display("FAIL single_latency: got gnt=%b, expected 000", gnt);
        end
        tick();
        n_checks++;
        if (gnt !== 3'b010 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: got gnt=%b busy=%b, expected 010 1", gnt, busy);
        end
        set_slot(s, 1'b1, 1'b1, 10'h005, 8'hA5);
        @(negedge clk);
        n_checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 10'h005, 8'hA5}) begin
            n_fail++;
            $display("FAIL single_write: got en=%b we=%b addr=%h wd=%h, expected 1 1 005 a5",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        tick();
        set_slot(s, 1'b1, 1'b0, 10'h005, 8'h00);
        e.k = s;
        e.d = 8'hA5;
        sb.push_back(e);
        tick();
        set_slot(s, 1'b0, 1'b0, 10'h000, 8'h00);
        @(negedge clk);
        n_checks++;
        if (rvalid !== 3'b010 || rdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_read: got rvalid=%b rdata=%h, expected 010 a5", rvalid, rdata);
        end
        req[s] = 1'b0;
        tick();
        tick();
        n_checks++;
        if (gnt !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: got gnt=%b busy=%b, expected 000 0", gnt, busy);
        end
    endtask

    task automatic test_handoff();
        req = 3'b001;
        tick();
        n_checks++;
        if (gnt !== 3'b001) begin
            n_fail++;
            $display("FAIL handoff_first: got gnt=%b, expected 001", gnt);
        end
        req[2] = 1'b1;
        do_burst(0, 10'h100, 8'h5A);
        n_checks++;
        if (gnt !== 3'b100 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL handoff_edge: got gnt=%b busy=%b, expected 100 1", gnt, busy);
        end
        do_burst(2, 10'h200, 8'hC3);
        n_checks++;
        if (gnt !== '0) begin
            n_fail++;
            $display("FAIL handoff_idle: got gnt=%b, expected 000", gnt);
        end
    endtask

    task automatic test_reset_pending_read();
        req = 3'b010;
        tick();
        n_checks++;
        if (gnt !== 3'b010) begin
            n_fail++;
            $display("FAIL rstrd_grant: got gnt=%b, expected 010", gnt);
        end
        set_slot(1, 1'b1, 1'b0, 10'h005, 8'h00);
        tick();
        rst = 1'b1;
        req = '0;
        acc = '0;
        @(negedge clk);
        n_checks++;
        if (rvalid !== '0) begin
            n_fail++;
            $display("FAIL rstrd_rvalid: got rvalid=%b, expected 000", rvalid);
        end
        tick();
        n_checks++;
        if ({gnt, rvalid, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL rstrd_outputs: got gnt=%b rvalid=%b rdata=%h busy=%b en=%b, expected 0",
                     gnt, rvalid, rdata, busy, mem_en);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (rvalid !== '0 || gnt !== '0) begin
            n_fail++;
            $display("FAIL rstrd_after: got rvalid=%b gnt=%b, expected 000 000", rvalid, gnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_arbitration();
        test_single();
        test_handoff();
        test_reset_pending_read();
        tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d reads outstanding, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
